// File: rtl/qnigma_pkg.sv
// Shared constants and types for the qnigma TCP receive path.
package qnigma_pkg;

  localparam int TCP_RX_FIFO_AW = 10;
  localparam int TCP_WSCALE     = 0;
  localparam int TCP_WUPD_THR   = 256;

  // Output stage of the RX FIFO: nothing pending / RAM read in flight / byte presented
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } tcp_rx_fifo_fsm_t;

endpackage

// File: rtl/qnigma_ram_dp.sv
// Simple dual-port RAM: port A synchronous write, port B registered read with enable.
module qnigma_ram_dp #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_din_i,
  input  logic          b_en_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_dout_o
);

  logic [DW-1:0] mem_q [0:2**AW-1];

  always_ff @(posedge clk_i) begin
    if (a_we_i) mem_q[a_addr_i] <= a_din_i;
  end

  // Read data holds while the port is not enabled so a prefetched byte survives stalls
  always_ff @(posedge clk_i) begin
    if (b_en_i) b_dout_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/qnigma_tcp_rx_fifo.sv
// TCP receive FIFO: buffers the in-order reassembled byte stream, presents it FWFT over
// valid/ready, and derives the advertised receive window plus window-update requests.
module qnigma_tcp_rx_fifo
  import qnigma_pkg::*;
#(
  parameter int AW       = TCP_RX_FIFO_AW,
  parameter int WSCALE   = TCP_WSCALE,
  parameter int WUPD_THR = TCP_WUPD_THR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [7:0]    in_dat,
  input  logic          in_val,
  output logic [7:0]    out_dat,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [AW:0]   cnt,
  output logic [15:0]   win,
  output logic          win_upd,
  input  logic          adv,
  output logic          ovf
);

  localparam int          DEPTH     = 2**AW;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam int          WIN_RST_I = ((DEPTH >> WSCALE) > 65535) ? 65535 : (DEPTH >> WSCALE);
  localparam logic [15:0] WIN_RST   = 16'(WIN_RST_I);
  localparam logic [16:0] THR_C     = 17'(WUPD_THR);

  function automatic logic [15:0] win_calc(input logic [AW:0] c);
    logic [AW:0] sh;
    sh = (DEPTH_C - c) >> WSCALE;
    return (32'(sh) > 32'd65535) ? 16'hFFFF : 16'(sh);
  endfunction

  tcp_rx_fifo_fsm_t state_q, state_d;
  logic             pf_q, pf_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic [7:0]       out_dat_q;
  logic             ovf_q, win_upd_q;
  logic [15:0]      adv_win_q;
  logic [7:0]       ram_dout;

  logic        full, wr_acc, take, ram_vld, has_more, rd_en, load_out;
  logic [AW:0] unread;

  assign full     = (cnt_q == DEPTH_C);
  assign wr_acc   = in_val && !full && !flush;
  assign take     = (state_q == VALID) && out_rdy && !flush;
  assign ram_vld  = (state_q == FETCH) || ((state_q == VALID) && pf_q);
  // Bytes still sitting in RAM that have not been read out yet
  assign unread   = cnt_q - (AW+1)'(state_q == VALID) - (AW+1)'(ram_vld);
  assign has_more = (unread != '0);
  assign cnt_d    = flush ? '0 : cnt_q + (AW+1)'(wr_acc) - (AW+1)'(take);

  qnigma_ram_dp #(.AW(AW), .DW(8)) u_ram (
    .clk_i    (clk),
    .a_we_i   (wr_acc),
    .a_addr_i (wr_ptr_q),
    .a_din_i  (in_dat),
    .b_en_i   (rd_en),
    .b_addr_i (rd_ptr_q),
    .b_dout_o (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
    end
  end

  // pf_q marks a byte already read from RAM and waiting behind the output register
  always_comb begin
    state_d = state_q;
    pf_d    = pf_q;
    if (flush) begin
      state_d = EMPTY;
      pf_d    = 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (rd_en) state_d = FETCH;
        FETCH: begin
          state_d = VALID;
          pf_d    = rd_en;
        end
        VALID: begin
          if (pf_q) begin
            if (take) pf_d = rd_en;
          end else if (take) begin
            state_d = rd_en ? FETCH : EMPTY;
            pf_d    = 1'b0;
          end else begin
            pf_d = rd_en;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_out = 1'b0;
    rd_en    = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: rd_en = has_more;
        FETCH: begin
          load_out = 1'b1;
          rd_en    = has_more;
        end
        VALID: begin
          if (pf_q) begin
            load_out = take;
            rd_en    = take && has_more;
          end else begin
            rd_en = has_more;
          end
        end
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_dat_q <= '0;
      ovf_q     <= 1'b0;
      win_upd_q <= 1'b0;
      adv_win_q <= WIN_RST;
    end else begin
      cnt_q <= cnt_d;
      if (load_out) out_dat_q <= ram_dout;
      if (flush) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        ovf_q     <= 1'b0;
        win_upd_q <= 1'b0;
        adv_win_q <= WIN_RST;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (in_val && full) ovf_q <= 1'b1;
        // An advertisement resets the reference; growth is judged against it from next cycle
        if (adv) begin
          adv_win_q <= win;
          win_upd_q <= 1'b0;
        end else if ((win >= adv_win_q) && ({1'b0, win - adv_win_q} >= THR_C)) begin
          win_upd_q <= 1'b1;
        end
      end
    end
  end

  assign out_dat = out_dat_q;
  assign out_val = (state_q == VALID);
  assign cnt     = cnt_q;
  assign win     = win_calc(cnt_q);
  assign win_upd = win_upd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_qnigma_tcp_rx_fifo.sv
// Bench for qnigma_tcp_rx_fifo: a 16-byte instance for directed/corner sequences and a
// 1024-byte instance for a randomized ordering and hold-stability run.
module tb_qnigma_tcp_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // small instance (AW=4, WUPD_THR=8)
  logic        s_flush = 0, s_in_val = 0, s_out_rdy = 0, s_adv = 0;
  logic [7:0]  s_in_dat = 0, s_out_dat;
  logic        s_out_val, s_win_upd, s_ovf;
  logic [4:0]  s_cnt;
  logic [15:0] s_win;

  // large instance (AW=10)
  logic        b_flush = 0, b_in_val = 0, b_out_rdy = 0, b_adv = 0;
  logic [7:0]  b_in_dat = 0, b_out_dat;
  logic        b_out_val, b_win_upd, b_ovf;
  logic [10:0] b_cnt;
  logic [15:0] b_win;

  qnigma_tcp_rx_fifo #(.AW(4), .WSCALE(0), .WUPD_THR(8)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_dat(s_in_dat), .in_val(s_in_val),
    .out_dat(s_out_dat), .out_val(s_out_val), .out_rdy(s_out_rdy), .cnt(s_cnt),
    .win(s_win), .win_upd(s_win_upd), .adv(s_adv), .ovf(s_ovf)
  );

  qnigma_tcp_rx_fifo #(.AW(10), .WSCALE(0), .WUPD_THR(256)) u_big (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_dat(b_in_dat), .in_val(b_in_val),
    .out_dat(b_out_dat), .out_val(b_out_val), .out_rdy(b_out_rdy), .cnt(b_cnt),
    .win(b_win), .win_upd(b_win_upd), .adv(b_adv), .ovf(b_ovf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_flush = 0; s_in_val = 0; s_out_rdy = 0; s_adv = 0; s_in_dat = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // one user transfer on the small instance, checking the presented byte first
  task automatic rd1(input logic [7:0] exp, input string nm);
    chk({nm, "_val"}, s_out_val, 1);
    chk({nm, "_dat"}, s_out_dat, exp);
    s_out_rdy = 1'b1;
    tick();
    s_out_rdy = 1'b0;
  endtask

  typedef struct {
    logic       in_val;
    logic [7:0] in_dat;
    logic       out_rdy;
    logic       ov;
    logic [7:0] od;
    logic [4:0] cnt;
    logic [15:0] win;
  } vec_t;

  vec_t vt [0:7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] e, prev_dat, exp_b;
    logic       prev_hold;
    int         sent, cycles;

    vt[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 5'd1, 16'd15};
    vt[1] = '{1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 5'd2, 16'd14};
    vt[2] = '{1'b1, 8'h13, 1'b1, 1'b1, 8'h11, 5'd3, 16'd13};
    vt[3] = '{1'b1, 8'h14, 1'b1, 1'b1, 8'h12, 5'd3, 16'd13};
    vt[4] = '{1'b1, 8'h15, 1'b1, 1'b1, 8'h13, 5'd3, 16'd13};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 5'd2, 16'd14};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h15, 5'd1, 16'd15};
    vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 16'd16};

    // reset state
    do_reset();
    #1;
    chk("rst_out_val", s_out_val, 0);
    chk("rst_out_dat", s_out_dat, 0);
    chk("rst_cnt", s_cnt, 0);
    chk("rst_win", s_win, 16);
    chk("rst_win_upd", s_win_upd, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_big_win", b_win, 1024);
    chk("rst_big_cnt", b_cnt, 0);

    // streaming latency and back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      s_in_val = vt[i].in_val;
      s_in_dat = vt[i].in_dat;
      s_out_rdy = vt[i].out_rdy;
      tick();
      chk($sformatf("vec%0d_out_val", i), s_out_val, vt[i].ov);
      if (vt[i].ov) chk($sformatf("vec%0d_out_dat", i), s_out_dat, vt[i].od);
      chk($sformatf("vec%0d_cnt", i), s_cnt, vt[i].cnt);
      chk($sformatf("vec%0d_win", i), s_win, vt[i].win);
      chk($sformatf("vec%0d_ovf", i), s_ovf, 0);
    end
    s_out_rdy = 0;

    // overflow then window-update threshold
    do_reset();
    for (int i = 0; i < 17; i++) begin
      s_in_val = 1'b1;
      s_in_dat = 8'(32'h20 + i);
      tick();
      if (i == 15) chk("ovf_before_17th", s_ovf, 0);
    end
    s_in_val = 1'b0;
    chk("ovf_after_17th", s_ovf, 1);
    chk("full_cnt", s_cnt, 16);
    chk("full_win", s_win, 0);
    s_adv = 1'b1;
    tick();
    s_adv = 1'b0;
    chk("adv_full_upd", s_win_upd, 0);
    tick();
    chk("adv_full_upd2", s_win_upd, 0);
    for (int i = 0; i < 7; i++) begin
      e = 8'(32'h20 + i);
      rd1(e, $sformatf("drain%0d", i));
    end
    chk("read7_win", s_win, 7);
    chk("read7_upd", s_win_upd, 0);
    tick();
    chk("read7_upd_late", s_win_upd, 0);
    rd1(8'h27, "drain7");
    chk("read8_cnt", s_cnt, 8);
    chk("read8_upd_same", s_win_upd, 0);
    tick();
    chk("read8_upd_next", s_win_upd, 1);
    s_adv = 1'b1;
    tick();
    s_adv = 1'b0;
    chk("adv_clears_upd", s_win_upd, 0);
    tick();
    chk("adv_stays_clear", s_win_upd, 0);
    for (int i = 8; i < 16; i++) begin
      e = 8'(32'h20 + i);
      rd1(e, $sformatf("drain%0d", i));
    end
    chk("drained_out_val", s_out_val, 0);
    chk("drained_cnt", s_cnt, 0);
    chk("drained_win", s_win, 16);
    tick();
    chk("regrow_upd", s_win_upd, 1);
    chk("ovf_sticky", s_ovf, 1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      s_in_val = 1'b1;
      s_in_dat = 8'(32'h41 + i);
      tick();
    end
    s_in_val = 1'b0;
    tick();
    tick();
    chk("pre_areset_val", s_out_val, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_out_val", s_out_val, 0);
    chk("areset_cnt", s_cnt, 0);
    chk("areset_upd", s_win_upd, 0);
    chk("areset_ovf", s_ovf, 0);
    chk("areset_win", s_win, 16);
    #2 rst_n = 1'b1;
    s_in_val = 1'b1;
    s_in_dat = 8'h77;
    tick();
    s_in_val = 1'b0;
    chk("post_rst_n_val", s_out_val, 0);
    chk("post_rst_n_cnt", s_cnt, 1);
    tick();
    chk("post_rst_n1_val", s_out_val, 0);
    tick();
    chk("post_rst_n2_val", s_out_val, 1);
    chk("post_rst_n2_dat", s_out_dat, 8'h77);

    // flush with 6 bytes buffered and a byte arriving in the flush cycle
    do_reset();
    for (int i = 0; i < 17; i++) begin
      s_in_val = 1'b1;
      s_in_dat = 8'(32'h60 + i);
      tick();
    end
    s_in_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e = 8'(32'h60 + i);
      rd1(e, $sformatf("pre_flush%0d", i));
    end
    chk("pre_flush_cnt", s_cnt, 6);
    chk("pre_flush_ovf", s_ovf, 1);
    s_flush = 1'b1; s_in_val = 1'b1; s_in_dat = 8'hEE; s_out_rdy = 1'b1;
    tick();
    s_flush = 1'b0; s_in_val = 1'b0; s_out_rdy = 1'b0;
    chk("flush_cnt", s_cnt, 0);
    chk("flush_out_val", s_out_val, 0);
    chk("flush_ovf", s_ovf, 0);
    chk("flush_win", s_win, 16);
    chk("flush_upd", s_win_upd, 0);
    tick();
    tick();
    chk("flush_idle_val", s_out_val, 0);
    chk("flush_idle_cnt", s_cnt, 0);
    s_in_val = 1'b1;
    s_in_dat = 8'h5A;
    tick();
    s_in_val = 1'b0;
    tick();
    tick();
    chk("after_flush_val", s_out_val, 1);
    chk("after_flush_dat", s_out_dat, 8'h5A);

    // randomized stream on the large instance
    sent = 0;
    cycles = 0;
    prev_hold = 1'b0;
    prev_dat = 8'h00;
    while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
      if (prev_hold) begin
        chk("rand_hold_val", b_out_val, 1);
        chk("rand_hold_dat", b_out_dat, prev_dat);
      end
      b_out_rdy = ($urandom_range(0, 1) == 1);
      if (b_out_val && b_out_rdy) begin
        chk("rand_q_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_b = q.pop_front();
          chk("rand_dat", b_out_dat, exp_b);
        end
      end
      prev_hold = b_out_val && !b_out_rdy;
      prev_dat = b_out_dat;
      b_in_val = (sent < 1000) && ($urandom_range(0, 9) < 6);
      if (b_in_val) begin
        b_in_dat = 8'($urandom);
        q.push_back(b_in_dat);
        sent++;
      end
      tick();
      cycles++;
    end
    b_in_val = 1'b0;
    b_out_rdy = 1'b0;
    chk("rand_in_budget", (cycles < 20000), 1);
    chk("rand_left", q.size(), 0);
    chk("rand_end_cnt", b_cnt, 0);
    chk("rand_end_win", b_win, 1024);
    chk("rand_ovf", b_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
